// File: rtl/alu_iter.sv
// Multi-cycle ALU with valid/ready handshakes; shifts iterate SHIFT_STEP bits per cycle.
// Optional compare operation enabled by defining ALU_CMP_EN.
module alu_iter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_sub,
  input  logic [1:0]      i_bool_op,
  input  logic [3:0]      i_op_sel,
  input  logic            i_shift_dir,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] SEL_ADD   = 4'b0001;
  localparam logic [3:0] SEL_CMP   = 4'b0010;
  localparam logic [3:0] SEL_BOOL  = 4'b0100;
  localparam logic [3:0] SEL_SHIFT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   sh_q;
  logic [SHW-1:0]    cnt_q;
  logic              sub_q;
  logic              dir_q;
  logic              fill_q;
  logic [1:0]        bool_q;
  logic [3:0]        sel_q;

  logic [XLEN-1:0]   exec_res;
  logic [CW-1:0]     step;
  logic [XLEN-1:0]   sh_next;

  // Single-cycle result for add/sub, bool, compare and invalid selects
  always_comb begin
    exec_res = '0;
    case (sel_q)
      SEL_ADD:  exec_res = sub_q ? (a_q - b_q) : (a_q + b_q);
      SEL_BOOL: begin
        case (bool_q)
          2'b00:   exec_res = a_q ^ b_q;
          2'b10:   exec_res = a_q | b_q;
          2'b11:   exec_res = a_q & b_q;
          default: exec_res = '0;
        endcase
      end
`ifdef ALU_CMP_EN
      SEL_CMP: begin
        if (sub_q) exec_res = XLEN'(a_q < b_q);
        else       exec_res = XLEN'($signed(a_q) < $signed(b_q));
      end
`endif
      default:  exec_res = '0;
    endcase
  end

  // One shift step of min(remaining, SHIFT_STEP); asr fills via inverted logical shift
  always_comb begin
    step = ({1'b0, cnt_q} < CW'(SHIFT_STEP)) ? {1'b0, cnt_q} : CW'(SHIFT_STEP);
    if (!dir_q)      sh_next = sh_q << step;
    else if (fill_q) sh_next = ~((~sh_q) >> step);
    else             sh_next = sh_q >> step;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_result <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      sub_q    <= 1'b0;
      dir_q    <= 1'b0;
      fill_q   <= 1'b0;
      bool_q   <= 2'b00;
      sel_q    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_q     <= i_op_a;
            b_q     <= i_op_b;
            sh_q    <= i_op_a;
            cnt_q   <= i_op_b[SHW-1:0];
            sub_q   <= i_sub;
            dir_q   <= i_shift_dir;
            fill_q  <= i_sub & i_shift_dir & i_op_a[XLEN-1];
            bool_q  <= i_bool_op;
            sel_q   <= i_op_sel;
            o_ready <= 1'b0;
            state   <= (i_op_sel == SEL_SHIFT) ? SHIFT : EXEC;
          end
        end
        EXEC: begin
          o_result <= exec_res;
          o_valid  <= 1'b1;
          state    <= DONE;
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            o_result <= sh_q;
            o_valid  <= 1'b1;
            state    <= DONE;
          end else begin
            sh_q  <= sh_next;
            cnt_q <= cnt_q - SHW'(step);
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: instance 0 uses SHIFT_STEP=8, instance 1 SHIFT_STEP=1.
module tb_alu_iter;

  localparam logic [3:0] ADD  = 4'b0001;
  localparam logic [3:0] CMP  = 4'b0010;
  localparam logic [3:0] BOOL = 4'b0100;
  localparam logic [3:0] SHF  = 4'b1000;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld  [2];
  logic        ordy [2];
  logic        sub  [2];
  logic        dir  [2];
  logic        ovld [2];
  logic        rdy  [2];
  logic [31:0] opa  [2];
  logic [31:0] opb  [2];
  logic [31:0] res  [2];
  logic [1:0]  bop  [2];
  logic [3:0]  sel  [2];

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        prev_v [2];
  logic [31:0] held   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_iter #(.XLEN(32), .SHIFT_STEP(g == 0 ? 8 : 1)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (vld[g]),
      .o_ready     (ordy[g]),
      .i_op_a      (opa[g]),
      .i_op_b      (opb[g]),
      .i_sub       (sub[g]),
      .i_bool_op   (bop[g]),
      .i_op_sel    (sel[g]),
      .i_shift_dir (dir[g]),
      .o_valid     (ovld[g]),
      .i_ready     (rdy[g]),
      .o_result    (res[g])
    );
  end

  // Monitor: pop on each new result, check value and cycle; check hold under backpressure
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        prev_v[k] = 1'b0;
      end else begin
        if (ovld[k] && !prev_v[k]) begin
          exp_t e;
          logic have;
          have = 1'b0;
          if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          total++;
          if (!have) begin
            bad++;
            $display("FAIL unexpected_result dut%0d: got %h at cyc %0d, want none", k, res[k], cyc);
          end else if (res[k] !== e.res || cyc != e.due || ordy[k] !== 1'b0) begin
            bad++;
            $display("FAIL %s dut%0d: got %h cyc %0d ready %b, want %h cyc %0d ready 0",
                     e.name, k, res[k], cyc, ordy[k], e.res, e.due);
          end
          held[k] = res[k];
        end else if (ovld[k] && prev_v[k]) begin
          total++;
          if (res[k] !== held[k] || ordy[k] !== 1'b0) begin
            bad++;
            $display("FAIL hold dut%0d: got %h ready %b, want %h ready 0", k, res[k], ordy[k], held[k]);
          end
        end
        prev_v[k] = ovld[k];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic issue(input int k, input string nm, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] b, input logic sb,
                       input logic [1:0] bo, input logic dr, input logic [31:0] want,
                       input int lat);
    exp_t e;
    int n;
    @(negedge clk);
    opa[k] = a; opb[k] = b; sub[k] = sb; bop[k] = bo; dir[k] = dr; sel[k] = s;
    vld[k] = 1'b1;
    n = 0;
    while (!ordy[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ordy[k]) begin
      total++; bad++;
      $display("FAIL %s_accept dut%0d: got ready 0, want ready 1 within 300 cycles", nm, k);
      vld[k] = 1'b0;
      return;
    end
    e.res = want; e.due = cyc + 1 + lat; e.name = nm;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    vld[k] = 1'b0;
    opa[k] = ~a; opb[k] = ~b; sub[k] = ~sb; bop[k] = ~bo; dir[k] = ~dr; sel[k] = 4'b0000;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; sub[k] = 1'b0; dir[k] = 1'b0; rdy[k] = 1'b1;
      opa[k] = '0; opb[k] = '0; bop[k] = 2'b00; sel[k] = 4'b0000;
      prev_v[k] = 1'b0; held[k] = '0;
    end
    vld[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(ovld[0]), 32'd0);
    chk("rst_result", res[0], 32'd0);
    vld[0] = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_ready0", 32'(ordy[0]), 32'd1);
    chk("rst_ready1", 32'(ordy[1]), 32'd1);

    issue(0, "add",     ADD,  32'd5,         32'd6,  1'b0, 2'b00, 1'b0, 32'd11,        1);
    issue(0, "sub",     ADD,  32'd5,         32'd6,  1'b1, 2'b00, 1'b0, 32'hFFFFFFFF,  1);
    issue(0, "sub0",    ADD,  32'd0,         32'd0,  1'b1, 2'b00, 1'b0, 32'd0,         1);
    issue(0, "addwrap", ADD,  32'hFFFFFFFF,  32'd2,  1'b0, 2'b00, 1'b0, 32'd1,         1);
    issue(0, "xor",     BOOL, 32'd1234,      32'd5678, 1'b0, 2'b00, 1'b0, 32'h000012FC, 1);
    issue(0, "or",      BOOL, 32'd1234,      32'd5678, 1'b0, 2'b10, 1'b0, 32'h000016FE, 1);
    issue(0, "and",     BOOL, 32'd1234,      32'd5678, 1'b0, 2'b11, 1'b0, 32'h00000402, 1);
    issue(0, "boolrsv", BOOL, 32'd1234,      32'd5678, 1'b0, 2'b01, 1'b0, 32'd0,        1);
    issue(0, "lsl8",    SHF,  32'h0000FFFF,  32'd8,  1'b0, 2'b00, 1'b0, 32'h00FFFF00,  2);
    issue(0, "lsr8",    SHF,  32'h0000FFFF,  32'd8,  1'b0, 2'b00, 1'b1, 32'h000000FF,  2);
    issue(0, "asr8",    SHF,  32'hF000FFFF,  32'd8,  1'b1, 2'b00, 1'b1, 32'hFFF000FF,  2);
    issue(0, "lsr8neg", SHF,  32'hF000FFFF,  32'd8,  1'b0, 2'b00, 1'b1, 32'h00F000FF,  2);
    issue(0, "lsr31",   SHF,  32'h80000000,  32'd31, 1'b0, 2'b00, 1'b1, 32'h00000001,  5);
    issue(0, "asr31",   SHF,  32'h80000000,  32'd31, 1'b1, 2'b00, 1'b1, 32'hFFFFFFFF,  5);
    issue(0, "lsl13",   SHF,  32'h00000001,  32'd13, 1'b0, 2'b00, 1'b0, 32'h00002000,  3);
    issue(0, "shift0",  SHF,  32'hDEADBEEF,  32'd0,  1'b1, 2'b00, 1'b1, 32'hDEADBEEF,  1);
    issue(0, "shift32", SHF,  32'hDEADBEEF,  32'd32, 1'b0, 2'b00, 1'b0, 32'hDEADBEEF,  1);
    issue(0, "sel0000", 4'b0000, 32'd5,      32'd6,  1'b0, 2'b00, 1'b0, 32'd0,         1);
    issue(0, "sel0011", 4'b0011, 32'd5,      32'd6,  1'b0, 2'b00, 1'b0, 32'd0,         1);
    issue(0, "sel1100", 4'b1100, 32'd5,      32'd6,  1'b0, 2'b00, 1'b0, 32'd0,         1);
`ifdef ALU_CMP_EN
    issue(0, "cmp_s",   CMP,  32'hFFFFFFFF,  32'd1,  1'b0, 2'b00, 1'b0, 32'd1,         1);
    issue(0, "cmp_u",   CMP,  32'hFFFFFFFF,  32'd1,  1'b1, 2'b00, 1'b0, 32'd0,         1);
    issue(0, "cmp_s2",  CMP,  32'd1,  32'hFFFFFFFF,  1'b0, 2'b00, 1'b0, 32'd0,         1);
    issue(0, "cmp_u2",  CMP,  32'd1,  32'hFFFFFFFF,  1'b1, 2'b00, 1'b0, 32'd1,         1);
`else
    issue(0, "cmp_off", CMP,  32'hFFFFFFFF,  32'd1,  1'b0, 2'b00, 1'b0, 32'd0,         1);
    issue(0, "cmp_offu", CMP, 32'd1,  32'hFFFFFFFF,  1'b1, 2'b00, 1'b0, 32'd0,         1);
`endif

    issue(1, "s1_lsl31", SHF, 32'h00000001,  32'd31, 1'b0, 2'b00, 1'b0, 32'h80000000, 32);
    issue(1, "s1_asr3",  SHF, 32'h80000000,  32'd3,  1'b1, 2'b00, 1'b1, 32'hF0000000,  4);
    issue(1, "s1_sh0",   SHF, 32'h12345678,  32'd0,  1'b0, 2'b00, 1'b0, 32'h12345678,  1);

    // Backpressure: hold result 4 cycles while a second request waits
    rdy[0] = 1'b0;
    issue(0, "bp_add", ADD, 32'd7, 32'd8, 1'b0, 2'b00, 1'b0, 32'd15, 1);
    fork
      issue(0, "bp_next", ADD, 32'd100, 32'd1, 1'b1, 2'b00, 1'b0, 32'd99, 1);
      begin
        n = 0;
        while (!ovld[0] && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_valid", 32'(ovld[0]), 32'd1);
        repeat (4) begin
          @(negedge clk);
          chk("bp_ready", 32'(ordy[0]), 32'd0);
        end
        rdy[0] = 1'b1;
      end
    join

    // Asynchronous reset in the middle of a shift
    issue(0, "abort", SHF, 32'h80000000, 32'd31, 1'b0, 2'b00, 1'b1, 32'd1, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    q0.delete();
    chk("abort_valid", 32'(ovld[0]), 32'd0);
    chk("abort_result", res[0], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready", 32'(ordy[0]), 32'd1);
    repeat (8) @(negedge clk);
    issue(0, "post_rst", ADD, 32'd2, 32'd3, 1'b0, 2'b00, 1'b0, 32'd5, 1);

    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || ovld[0] || ovld[1]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    while (q0.size() > 0) begin
      exp_t e;
      e = q0.pop_front();
      total++; bad++;
      $display("FAIL %s dut0: got no result, want %h", e.name, e.res);
    end
    while (q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      total++; bad++;
      $display("FAIL %s dut1: got no result, want %h", e.name, e.res);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
